seven_segment_scanner: RTL and testbench

Time-multiplexed driver for a common-anode multi-digit seven-segment display. Takes a packed vector of BCD digits plus decimal points, snapshots it once per frame, and cycles through the digits one slot at a time. Each slot starts with an anti-ghosting blank interval. It produces the 4-bit DIGIT code consumed by `seven_segment_decoder`. It then drives active-low ANODE and CATHODE pins from the decoded pattern, and sits between the timer datapath and the board pins.

---
 rtl/seven_seg_pkg.sv | 12 +
 rtl/seven_segment_decoder.sv | 27 ++
 rtl/seven_segment_scanner.sv | 159 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and state encoding for the seven-segment scanner and its decoder.
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK   = 8'h00;  // active-high decoder output, all segments off
    localparam logic [7:0] CATHODE_OFF = 8'hFF;  // active-low pins, all segments off

    typedef enum logic {
        OFF,
        RUN
    } scan_state_t;

endpackage

// File: rtl/seven_segment_decoder.sv
// BCD to seven-segment decoder, active-high, bit 7 always 0, bits 6..0 = g..a.
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    // NOTE: assigning a default before the case keeps this purely combinational (no latch).
    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = 8'h3F;
            4'd1:    seg_o = 8'h06;
            4'd2:    seg_o = 8'h5B;
            4'd3:    seg_o = 8'h4F;
            4'd4:    seg_o = 8'h66;
            4'd5:    seg_o = 8'h6D;
            4'd6:    seg_o = 8'h7D;
            4'd7:    seg_o = 8'h07;
            4'd8:    seg_o = 8'h7F;
            4'd9:    seg_o = 8'h6F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode display driver: per-frame snapshot, per-slot blanking,
// optional leading-zero suppression, registered active-low ANODE/CATHODE pins.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_leading_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [7:0]              cathode_o,
    output logic                    frame_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]              cathode_q, cathode_d;
    logic                    frame_q, frame_d;

    logic                    load_snap;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [3:0]              sel_nibble;
    logic                    sel_dp;
    logic                    sel_suppress;
    logic                    in_blank;
    logic [7:0]              dec_seg;

    // Sequencer: slot counter, slot index and snapshot reload at each frame start.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        load_snap     = 1'b0;

        unique case (state_q)
            OFF: begin
                if (enable_i) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    idx_d     = '0;
                    load_snap = 1'b1;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        load_snap = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = OFF;
        endcase

        if (load_snap) begin
            snap_digits_d = digits_i;
            snap_dp_d     = dp_i;
        end
        frame_d = load_snap;
    end

    // A slot stays dark only while it and every more-significant slot hold zero with no DP,
    // so a lit decimal point keeps the zeros to its right visible.
    always_comb begin
        logic tail_zero;
        tail_zero = 1'b1;
        suppress  = '0;
        for (int s = NUM_DIGITS - 1; s >= 0; s--) begin
            tail_zero   = tail_zero && (snap_digits_d[4*s +: 4] == 4'd0) && !snap_dp_d[s];
            suppress[s] = blank_leading_i && tail_zero;
        end
        suppress[0] = 1'b0;
    end

    always_comb begin
        sel_nibble   = 4'd0;
        sel_dp       = 1'b0;
        sel_suppress = 1'b0;
        for (int s = 0; s < NUM_DIGITS; s++) begin
            if (idx_d == IDX_W'(s)) begin
                sel_nibble   = snap_digits_d[4*s +: 4];
                sel_dp       = snap_dp_d[s];
                sel_suppress = suppress[s];
            end
        end
    end

    seven_segment_decoder u_decoder (
        .digit_i (sel_nibble),
        .seg_o   (dec_seg)
    );

    // Outputs are derived from the post-edge state so pins and counters stay aligned.
    always_comb begin
        in_blank  = int'(cnt_d) < BLANK_CYCLES;
        anode_d   = '1;
        cathode_d = CATHODE_OFF;
        if (state_d == RUN) begin
            cathode_d = ~({sel_dp, 7'b0} | (dec_seg & 8'h7F));
            if (!in_blank && !sel_suppress) begin
                anode_d = ~(NUM_DIGITS'(1) << idx_d);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= OFF;
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            anode_q       <= '1;
            cathode_q     <= CATHODE_OFF;
            frame_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            anode_q       <= anode_d;
            cathode_q     <= cathode_d;
            frame_q       <= frame_d;
        end
    end

    assign anode_o   = anode_q;
    assign cathode_o = cathode_q;
    assign frame_o   = frame_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_segment_scanner;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        blank_leading = 1'b0;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        frame;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [3:0] anode;
        logic [7:0] cathode;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        bl;
        int          slot;
        logic [3:0]  anode;
        logic [7:0]  cathode;
    } vec_t;
    vec_t vecs[18];

    seven_segment_scanner #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable),
        .digits_i        (digits),
        .dp_i            (dp),
        .blank_leading_i (blank_leading),
        .anode_o         (anode),
        .cathode_o       (cathode),
        .frame_o         (frame)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [3:0] a, input logic [7:0] c);
        exp_t e;
        e.name    = name;
        e.anode   = a;
        e.cathode = c;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.name, "_anode"}, {28'd0, anode}, {28'd0, e.anode});
            check({e.name, "_cathode"}, {24'd0, cathode}, {24'd0, e.cathode});
        end
    endtask

    // Leaves the bench just after the enabling edge (slot 0, CNT = 0).
    task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic b);
        enable = 1'b0;
        cycles(2);
        digits        = d;
        dp            = p;
        blank_leading = b;
        enable        = 1'b1;
        cycles(1);
    endtask

    initial begin
        int viol;
        int k;
        int frames;
        logic [7:0] prev_c;

        vecs[0]  = '{16'h1234, 4'b0000, 1'b0, 0, 4'b1110, 8'b10011001};
        vecs[1]  = '{16'h1234, 4'b0000, 1'b0, 1, 4'b1101, 8'b10110000};
        vecs[2]  = '{16'h1234, 4'b0000, 1'b0, 2, 4'b1011, 8'b10100100};
        vecs[3]  = '{16'h1234, 4'b0000, 1'b0, 3, 4'b0111, 8'b11111001};
        vecs[4]  = '{16'h0050, 4'b0000, 1'b1, 0, 4'b1110, 8'b11000000};
        vecs[5]  = '{16'h0050, 4'b0000, 1'b1, 1, 4'b1101, 8'b10010010};
        vecs[6]  = '{16'h0050, 4'b0000, 1'b1, 2, 4'b1111, 8'b11000000};
        vecs[7]  = '{16'h0050, 4'b0000, 1'b1, 3, 4'b1111, 8'b11000000};
        vecs[8]  = '{16'h0000, 4'b0000, 1'b1, 0, 4'b1110, 8'b11000000};
        vecs[9]  = '{16'h0000, 4'b0000, 1'b1, 1, 4'b1111, 8'b11000000};
        vecs[10] = '{16'h0050, 4'b1000, 1'b1, 3, 4'b0111, 8'b01000000};
        vecs[11] = '{16'h0050, 4'b1000, 1'b1, 2, 4'b1011, 8'b11000000};
        vecs[12] = '{16'h0050, 4'b0000, 1'b0, 3, 4'b0111, 8'b11000000};
        vecs[13] = '{16'h0B00, 4'b0100, 1'b0, 2, 4'b1011, 8'b01111111};
        vecs[14] = '{16'h9876, 4'b0000, 1'b0, 0, 4'b1110, 8'b10000010};
        vecs[15] = '{16'h9876, 4'b0000, 1'b0, 1, 4'b1101, 8'b11111000};
        vecs[16] = '{16'h9876, 4'b0000, 1'b0, 3, 4'b0111, 8'b10010000};
        vecs[17] = '{16'hF000, 4'b0000, 1'b0, 3, 4'b0111, 8'b11111111};

        // Asynchronous reset with no clock edge in between.
        #2 rst_n = 1'b0;
        #1;
        check("rst_anode", {28'd0, anode}, 32'hF);
        check("rst_cathode", {24'd0, cathode}, 32'hFF);
        check("rst_frame", {31'd0, frame}, 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        check("off_anode", {28'd0, anode}, 32'hF);
        check("off_cathode", {24'd0, cathode}, 32'hFF);
        check("off_frame", {31'd0, frame}, 32'd0);

        // Table: blank-interval sample then mid-slot lit sample for each vector.
        for (int i = 0; i < 18; i++) begin
            restart(vecs[i].digits, vecs[i].dp, vecs[i].bl);
            check($sformatf("vec%0d_frame", i), {31'd0, frame}, 32'd1);
            expect_out($sformatf("vec%0d_blank", i), 4'b1111, vecs[i].cathode);
            cycles(vecs[i].slot * DIV + 1);
            compare_out();
            expect_out($sformatf("vec%0d_lit", i), vecs[i].anode, vecs[i].cathode);
            cycles(3);
            compare_out();
        end

        // Frame period, pulse width and cathode stability while an anode is lit.
        restart(16'h1234, 4'b0000, 1'b0);
        cycles(1);
        check("frame_width", {31'd0, frame}, 32'd0);
        k = 1;
        while (frame == 1'b0 && k < 100) begin
            cycles(1);
            k++;
        end
        check("frame_period", k, N * DIV);
        viol   = 0;
        frames = 0;
        prev_c = cathode;
        for (int c = 0; c < 2 * N * DIV; c++) begin
            cycles(1);
            if (frame) frames++;
            if (cathode !== prev_c && anode !== 4'b1111) viol++;
            prev_c = cathode;
        end
        check("frame_count", frames, 2);
        check("cathode_stable", viol, 0);

        // Tearing: mid-frame input change waits for the next frame.
        restart(16'h1234, 4'b0000, 1'b0);
        cycles(9);
        digits = 16'h5678;
        expect_out("tear_slot1", 4'b1101, 8'b10110000);
        cycles(3);
        compare_out();
        expect_out("tear_slot2", 4'b1011, 8'b10100100);
        cycles(8);
        compare_out();
        expect_out("tear_slot3", 4'b0111, 8'b11111001);
        cycles(8);
        compare_out();
        expect_out("tear_next_slot0", 4'b1110, 8'b10000000);
        cycles(8);
        compare_out();

        // Disable mid-slot, then re-enable.
        restart(16'h1234, 4'b0000, 1'b0);
        cycles(12);
        expect_out("pre_disable", 4'b1101, 8'b10110000);
        compare_out();
        enable = 1'b0;
        cycles(1);
        expect_out("disabled", 4'b1111, 8'hFF);
        compare_out();
        check("disabled_frame", {31'd0, frame}, 32'd0);
        enable = 1'b1;
        cycles(1);
        check("reenable_frame", {31'd0, frame}, 32'd1);
        expect_out("reenable_blank0", 4'b1111, 8'b10011001);
        compare_out();
        cycles(1);
        expect_out("reenable_blank1", 4'b1111, 8'b10011001);
        compare_out();
        cycles(1);
        expect_out("reenable_lit", 4'b1110, 8'b10011001);
        compare_out();

        // Reset mid-show, released with enable held high.
        restart(16'h1234, 4'b0000, 1'b0);
        cycles(4);
        expect_out("pre_reset", 4'b1110, 8'b10011001);
        compare_out();
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_reset", 4'b1111, 8'hFF);
        compare_out();
        check("async_reset_frame", {31'd0, frame}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        check("post_reset_frame", {31'd0, frame}, 32'd1);
        cycles(2);
        expect_out("post_reset_lit", 4'b1110, 8'b10011001);
        compare_out();

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
